// File: rtl/qk_sequencer_pkg.sv
// qk_sequencer_pkg: inst encodings shared with the mac columns and the sequencer state enum
package qk_sequencer_pkg;
    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;
    typedef enum logic [2:0] {IDLE, CLR, LOAD, EXEC, DRAIN, DONE} state_t;
endpackage

// File: rtl/seq_addr_gen.sv
// seq_addr_gen: latched base plus offset counter, giving a wrapping SRAM address that holds on stall
module seq_addr_gen #(
    parameter int addr_w = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld,
    input  logic [addr_w-1:0] base,
    input  logic              step,
    input  logic              stall,
    output logic [addr_w-1:0] off,
    output logic [addr_w-1:0] addr
);
    logic [addr_w-1:0] base_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            base_q <= '0;
            off    <= '0;
        end else if (ld) begin
            base_q <= base;
            off    <= '0;
        end else if (step && !stall) begin
            off <= off + 1'b1;
        end
    assign addr = base_q + off;
endmodule

// File: rtl/qk_sequencer.sv
// qk_sequencer: fetches keys then queries from SRAM and issues the load/execute stream to the mac columns
module qk_sequencer
    import qk_sequencer_pkg::*;
#(
    parameter int bw     = 8,
    parameter int pr     = 8,
    parameter int col    = 8,
    parameter int addr_w = 6,
    parameter int drain  = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [addr_w-1:0] key_base,
    input  logic [addr_w-1:0] query_base,
    input  logic [addr_w-1:0] num_q,
    input  logic              ofifo_full,
    output logic              mem_cen,
    output logic [addr_w-1:0] mem_addr,
    input  logic [pr*bw-1:0]  mem_rdata,
    output logic              arr_reset,
    output logic [1:0]        inst,
    output logic [pr*bw-1:0]  q_data,
    output logic              busy,
    output logic              done
);
    localparam int dw = $clog2(drain + 1);
    state_t state, state_nx;
    logic [addr_w-1:0] qbase_q, nq_q, off;
    logic [dw-1:0] dcnt;
    logic last_k, last_q, ld, step, stall, issue;
    assign stall  = state == EXEC && ofifo_full;
    assign issue  = state == LOAD || (state == EXEC && !ofifo_full);
    assign last_k = off == addr_w'(col - 1);
    assign last_q = off == nq_q - 1'b1;
    assign ld     = (state == IDLE && start) || (state == LOAD && last_k);
    assign step   = state == LOAD || state == EXEC;
    // key base is taken straight from the port on start; the query base was latched at the same moment
    seq_addr_gen #(.addr_w(addr_w)) u_addr (
        .clk(clk),
        .reset_n(reset_n),
        .ld(ld),
        .base(state == IDLE ? key_base : qbase_q),
        .step(step),
        .stall(stall),
        .off(off),
        .addr(mem_addr)
    );
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = start ? CLR : IDLE;
            CLR:     state_nx = LOAD;
            LOAD:    state_nx = !last_k ? LOAD : (nq_q == '0 ? DRAIN : EXEC);
            EXEC:    state_nx = (!ofifo_full && last_q) ? DRAIN : EXEC;
            DRAIN:   state_nx = dcnt == dw'(drain - 1) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state   <= IDLE;
            qbase_q <= '0;
            nq_q    <= '0;
            dcnt    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                qbase_q <= query_base;
                nq_q    <= num_q;
            end
            dcnt <= state == DRAIN ? dcnt + 1'b1 : '0;
        end
    assign inst      = state == LOAD ? INST_LOAD : issue ? INST_EXEC : INST_IDLE;
    assign mem_cen   = !issue;
    assign arr_reset = state == CLR;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign q_data    = mem_rdata;
endmodule

// File: tb/tb_qk_sequencer.sv
// tb_qk_sequencer: directed and randomized jobs checked cycle by cycle against an expected trace
module tb_qk_sequencer;
    localparam int bw = 8, pr = 8, col = 8, addr_w = 6, drain = 7;
    logic clk = 0, reset_n = 1, start = 0, ofifo_full = 0;
    logic mem_cen, arr_reset, busy, done;
    logic [addr_w-1:0] key_base = '0, query_base = '0, num_q = '0, mem_addr;
    logic [pr*bw-1:0] mem_rdata = '0, q_data;
    logic [1:0] inst;
    logic [pr*bw-1:0] mem [64];
    int total = 0, bad = 0;
    typedef struct {
        bit arr;
        bit [1:0] inst;
        bit cen;
        bit chk_addr;
        bit [5:0] addr;
        bit full;
        bit done;
    } rec_t;
    rec_t tr[$];

    qk_sequencer #(.bw(bw), .pr(pr), .col(col), .addr_w(addr_w), .drain(drain)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .key_base(key_base),
        .query_base(query_base), .num_q(num_q), .ofifo_full(ofifo_full),
        .mem_cen(mem_cen), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .arr_reset(arr_reset), .inst(inst), .q_data(q_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (!mem_cen) mem_rdata <= mem[mem_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic rec_t mk(bit a, bit [1:0] i, bit c, bit k, bit [5:0] ad, bit f, bit d);
        rec_t r;
        r.arr = a; r.inst = i; r.cen = c; r.chk_addr = k; r.addr = ad; r.full = f; r.done = d;
        return r;
    endfunction

    // expected trace from the cycle after start acceptance through the done cycle
    task automatic build(input logic [5:0] kb, input logic [5:0] qb, input logic [5:0] nq, input int mode);
        int j = 0, ec = 0;
        bit f;
        tr.delete();
        tr.push_back(mk(1, 2'b00, 1, 0, 6'd0, 0, 0));
        for (int i = 0; i < col; i++)
            tr.push_back(mk(0, 2'b01, 0, 1, 6'(kb + i), mode == 2 && $urandom_range(0, 1) == 1, 0));
        while (j < int'(nq)) begin
            f = mode == 1 ? (ec == 1 || ec == 2) : (mode == 2 && $urandom_range(0, 3) == 0);
            tr.push_back(mk(0, f ? 2'b00 : 2'b10, f, 1, 6'(qb + j), f, 0));
            if (!f) j++;
            ec++;
        end
        for (int i = 0; i < drain; i++)
            tr.push_back(mk(0, 2'b00, 1, 0, 6'd0, mode == 2 && $urandom_range(0, 1) == 1, 0));
        tr.push_back(mk(0, 2'b00, 1, 0, 6'd0, 0, 1));
    endtask

    task automatic run_job(input logic [5:0] kb, input logic [5:0] qb, input logic [5:0] nq,
                           input int mode, input int busy_at, input int abort_q);
        int nq_seen = 0;
        bit pi = 0;
        logic [5:0] pa = '0;
        build(kb, qb, nq, mode);
        @(negedge clk);
        key_base = kb; query_base = qb; num_q = nq; start = 1;
        @(negedge clk);
        start = 0; key_base = 6'($urandom); query_base = 6'($urandom); num_q = 6'($urandom);
        foreach (tr[c]) begin
            ofifo_full = tr[c].full;
            start = (c == busy_at);
            #1;
            chk("arr_reset", arr_reset, tr[c].arr);
            chk("inst", inst, tr[c].inst);
            chk("mem_cen", mem_cen, tr[c].cen);
            if (tr[c].chk_addr) chk("mem_addr", mem_addr, tr[c].addr);
            chk("busy", busy, 1);
            chk("done", done, tr[c].done);
            if (pi) chk("q_data", q_data, mem[pa]);
            pi = !tr[c].cen;
            pa = tr[c].addr;
            if (tr[c].inst == 2'b10) nq_seen++;
            @(negedge clk);
            if (abort_q >= 0 && nq_seen == abort_q) begin
                start = 0; ofifo_full = 0; reset_n = 0;
                #1;
                chk("abort_inst", inst, 2'b00);
                chk("abort_cen", mem_cen, 1);
                chk("abort_addr", mem_addr, 0);
                chk("abort_arr", arr_reset, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_no_done", done, 0);
                end
                reset_n = 1;
                return;
            end
        end
        start = 0; ofifo_full = 0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_inst", inst, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
        #2 reset_n = 0;
        #1;
        chk("rst_inst", inst, 2'b00);
        chk("rst_cen", mem_cen, 1);
        chk("rst_addr", mem_addr, 0);
        chk("rst_arr", arr_reset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        run_job(6'd0, 6'd8, 6'd4, 0, -1, -1);
        run_job(6'd0, 6'd8, 6'd4, 1, -1, -1);
        run_job(6'd5, 6'd20, 6'd0, 0, -1, -1);
        run_job(6'd60, 6'd30, 6'd3, 0, -1, -1);
        run_job(6'd10, 6'd40, 6'd5, 0, 3, -1);
        run_job(6'd0, 6'd8, 6'd4, 0, -1, 2);
        run_job(6'd0, 6'd8, 6'd4, 0, -1, -1);
        for (int n = 0; n < 20; n++)
            run_job(6'($urandom), 6'($urandom), 6'($urandom_range(0, 12)), 2,
                    $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 8)) : -1, -1);
        run_job(6'd3, 6'd50, 6'd63, 2, -1, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
